// File: rtl/adder_pkg.sv
// Shared definitions for the chunked ripple adder: FSM state encoding and default geometry.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package adder_pkg;

    // Default operand width and bits added per cycle.
    localparam int ADDER_WIDTH_DEF = 32;
    localparam int ADDER_CHUNK_DEF = 4;

    // Controller states. The encoding is fixed so the values line up with
    // older code that used plain 2-bit constants.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } adder_state_e;

endpackage

// File: rtl/ripple_chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from per-bit full adders.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; it is a pure function of its inputs.
//
// Ports:
//   a, b       CHUNK-bit addends
//   carry_in   carry into bit 0
//   sum        CHUNK-bit result
//   carry_out  carry out of bit CHUNK-1
module ripple_chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             carry_in,
    output logic [CHUNK-1:0] sum,
    output logic             carry_out
);

    logic [CHUNK:0] carry_chain;

    assign carry_chain[0] = carry_in;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]           = a[i] ^ b[i] ^ carry_chain[i];
        assign carry_chain[i+1] = (a[i] & b[i]) | (carry_chain[i] & (a[i] ^ b[i]));
    end

    assign carry_out = carry_chain[CHUNK];

endmodule

// File: rtl/seq_chunked_adder.sv
// Multi-cycle adder: adds two WIDTH-bit operands CHUNK bits per clock, carry registered between chunks.
// Latency: result valid WIDTH/CHUNK cycles after acceptance; one operation in flight at a time.
// Backpressure: holds the result in DONE while out_ready=0; in_ready stays low until the result is taken.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (a, b, carry_in[, op_sub])
//   out_valid / out_ready result handshake (sum, carry_out, overflow)
// Optional feature: define ADDER_SUB_EN to add the op_sub input (a - b when set).
module seq_chunked_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH_DEF,
    parameter int CHUNK = ADDER_CHUNK_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
`ifdef ADDER_SUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    adder_state_e     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [CHUNK-1:0] chunk_a, chunk_b, chunk_sum;
    logic             chunk_cout;
    logic             accept, last_chunk;

    // Subtraction is a + ~b + 1, so the initial carry is forced high.
`ifdef ADDER_SUB_EN
    assign b_eff   = op_sub ? ~b : b;
    assign cin_eff = op_sub ? 1'b1 : carry_in;
`else
    assign b_eff   = b;
    assign cin_eff = carry_in;
`endif

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign accept     = in_valid && in_ready;
    assign last_chunk = (idx_q == IDX_W'(NCHUNK - 1));

    // Select the operand slice for the current chunk index.
    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDX_W'(i)) begin
                chunk_a = a_q[i*CHUNK +: CHUNK];
                chunk_b = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    ripple_chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a         (chunk_a),
        .b         (chunk_b),
        .carry_in  (carry_q),
        .sum       (chunk_sum),
        .carry_out (chunk_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d     = a;
                    b_d     = b_eff;
                    carry_d = cin_eff;
                    sum_d   = '0;
                    ovf_d   = 1'b0;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < NCHUNK; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[i*CHUNK +: CHUNK] = chunk_sum;
                    end
                end
                carry_d = chunk_cout;
                idx_d   = idx_q + 1'b1;
                if (last_chunk) begin
                    // The final chunk carries the result MSB, so signed
                    // overflow is resolved here and then held.
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (chunk_sum[CHUNK-1] != a_q[WIDTH-1]);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum       = sum_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_chunked_adder.sv
// Directed bench for seq_chunked_adder: a 16/4 instance and a 16/16 instance.
// Latency: checks 4-cycle and 1-cycle result latency.
// Backpressure: holds out_ready low to check the result is held stable.
module tb_seq_chunked_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid4, in_valid16;
    logic [15:0] a, b;
    logic        carry_in;
    logic        op_sub;
    logic        out_ready;

    logic        in_ready4, out_valid4, cout4, ovf4;
    logic [15:0] sum4;
    logic        in_ready16, out_valid16, cout16, ovf16;
    logic [15:0] sum16;

    logic        sel_wide;
    logic        cur_in_ready, cur_out_valid, cur_cout, cur_ovf;
    logic [15:0] cur_sum;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_chunked_adder #(.WIDTH(16), .CHUNK(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
`ifdef ADDER_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .sum       (sum4),
        .carry_out (cout4),
        .overflow  (ovf4)
    );

    seq_chunked_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
`ifdef ADDER_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid16),
        .out_ready (out_ready),
        .sum       (sum16),
        .carry_out (cout16),
        .overflow  (ovf16)
    );

    assign cur_in_ready  = sel_wide ? in_ready16  : in_ready4;
    assign cur_out_valid = sel_wide ? out_valid16 : out_valid4;
    assign cur_sum       = sel_wide ? sum16       : sum4;
    assign cur_cout      = sel_wide ? cout16      : cout4;
    assign cur_ovf       = sel_wide ? ovf16       : ovf4;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one operation; returns just after the accepting edge.
    task automatic start_op(input logic wide, input logic [15:0] av, input logic [15:0] bv,
                            input logic cin, input logic sub);
        sel_wide = wide;
        a        = av;
        b        = bv;
        carry_in = cin;
        op_sub   = sub;
        if (wide) in_valid16 = 1'b1; else in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4  = 1'b0;
        in_valid16 = 1'b0;
        // Operands must be ignored while the operation runs.
        a        = 16'hDEAD;
        b        = 16'hBEEF;
        carry_in = ~cin;
        op_sub   = ~sub;
    endtask

    // Count edges until out_valid; leaves the bench #1 after that edge.
    task automatic wait_result(input string tag, input int exp_lat);
        int lat = 0;
        while (!cur_out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
    endtask

    task automatic check_result(input string tag, input logic [15:0] es, input logic ec, input logic eo);
        check({tag, "_sum"},  {16'h0, cur_sum}, {16'h0, es});
        check({tag, "_cout"}, {31'h0, cur_cout}, {31'h0, ec});
        check({tag, "_ovf"},  {31'h0, cur_ovf},  {31'h0, eo});
    endtask

    // Let the result be taken (out_ready is high), then check the return to IDLE.
    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_rdy_after"}, {31'h0, cur_in_ready}, 32'h1);
        check({tag, "_vld_after"}, {31'h0, cur_out_valid}, 32'h0);
    endtask

    initial begin
        logic seen_vld;
        logic stable;
        rst_n      = 1'b0;
        in_valid4  = 1'b0;
        in_valid16 = 1'b0;
        a          = '0;
        b          = '0;
        carry_in   = 1'b0;
        op_sub     = 1'b0;
        out_ready  = 1'b1;
        sel_wide   = 1'b0;

        // Reset values.
        #12;
        check("rst_in_ready",  {31'h0, in_ready4},  32'h1);
        check("rst_out_valid", {31'h0, out_valid4}, 32'h0);
        check("rst_sum",       {16'h0, sum4},       32'h0);
        check("rst_cout",      {31'h0, cout4},      32'h0);
        check("rst_ovf",       {31'h0, ovf4},       32'h0);
        check("rst16_ready",   {31'h0, in_ready16}, 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Unsigned wrap: FFFF + 1 = 0 with carry, no signed overflow.
        start_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_result("wrap", 4);
        check_result("wrap", 16'h0000, 1'b1, 1'b0);
        finish_op("wrap");

        // Signed overflow: 7FFF + 1 = 8000.
        start_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_result("sovf", 4);
        check_result("sovf", 16'h8000, 1'b0, 1'b1);
        finish_op("sovf");

        // All ones plus carry: FFFF + FFFF + 1 = 1_FFFF, no overflow.
        start_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        wait_result("ones", 4);
        check_result("ones", 16'hFFFF, 1'b1, 1'b0);
        finish_op("ones");

        // Backpressure: hold out_ready low for 10 cycles.
        out_ready = 1'b0;
        start_op(1'b0, 16'h1234, 16'h1111, 1'b0, 1'b0);
        wait_result("bp", 4);
        check_result("bp", 16'h2345, 1'b0, 1'b0);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!out_valid4 || in_ready4 || sum4 !== 16'h2345 || cout4 !== 1'b0)
                stable = 1'b0;
        end
        check("bp_stable", {31'h0, stable}, 32'h1);
        finish_op("bp");

        // Reset after two chunks: abort, never present the partial result.
        start_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", {31'h0, in_ready4},  32'h1);
        check("mid_rst_vld",   {31'h0, out_valid4}, 32'h0);
        check("mid_rst_sum",   {16'h0, sum4},       32'h0);
        check("mid_rst_cout",  {31'h0, cout4},      32'h0);
        seen_vld = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            seen_vld = seen_vld | out_valid4;
        end
        check("mid_rst_no_vld", {31'h0, seen_vld}, 32'h0);
        start_op(1'b0, 16'h1234, 16'h1111, 1'b1, 1'b0);
        wait_result("after_rst", 4);
        check_result("after_rst", 16'h2346, 1'b0, 1'b0);
        finish_op("after_rst");

        // Single-chunk instance: latency 1.
        start_op(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0);
        wait_result("w16", 1);
        check_result("w16", 16'h0000, 1'b1, 1'b1);
        finish_op("w16");

`ifdef ADDER_SUB_EN
        // 5 - 7 = -2, borrow (carry_out=0); carry_in is ignored.
        start_op(1'b0, 16'h0005, 16'h0007, 1'b0, 1'b1);
        wait_result("sub4", 4);
        check_result("sub4", 16'hFFFE, 1'b0, 1'b0);
        finish_op("sub4");

        start_op(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1);
        wait_result("sub16", 1);
        check_result("sub16", 16'hFFFE, 1'b0, 1'b0);
        finish_op("sub16");

        // 7 - 5 = 2, no borrow.
        start_op(1'b0, 16'h0007, 16'h0005, 1'b0, 1'b1);
        wait_result("sub_nb", 4);
        check_result("sub_nb", 16'h0002, 1'b1, 1'b0);
        finish_op("sub_nb");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
